// File: rtl/mem_wait_responder_if.sv
// Unified instruction/data memory port between the multicycle core and its
// wait-state memory responder.
interface mem_wait_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              irwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] instr;
  logic              overrun;

  modport master (
    output req, we, irwrite, addr, wdata,
    input  ack, busy, rdata, instr, overrun
  );

  modport slave (
    input  req, we, irwrite, addr, wdata,
    output ack, busy, rdata, instr, overrun
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Memory responder with req/ack handshake and WAIT_CYCLES (0..15) wait states;
// owns the word array, the read-data register and the instruction register.
module mem_wait_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_wait_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              irwrite_q, irwrite_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] instr_q;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic busy;
  logic in_access;

  assign busy      = (state_q != ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    irwrite_d = irwrite_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    overrun_d = overrun_q | (bus.req & busy);

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d      = bus.we;
          irwrite_d = bus.irwrite;
          addr_d    = bus.addr;
          wdata_d   = bus.wdata;
          cnt_d     = WAIT_INIT;
          state_d   = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        // Leaving on count 1 gives exactly WAIT_CYCLES cycles in this state.
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
        cnt_d = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      irwrite_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      irwrite_q <= irwrite_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
    end
  end

  // A reset landing on the access edge must not commit the write.
  always_ff @(posedge clk) begin
    if (!reset && in_access && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      instr_q <= '0;
    end else if (in_access && !we_q) begin
      rdata_q <= mem[addr_q];
      if (irwrite_q) begin
        instr_q <= mem[addr_q];
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy;
  assign bus.rdata   = rdata_q;
  assign bus.instr   = instr_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance share stimulus; sel chooses which one's outputs are checked.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        rst2, rst0;
  logic        req, we, irwrite;
  logic [6:0]  addr;
  logic [31:0] wdata;
  bit          sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wait_responder_if #(.ADDR_W(7), .DATA_W(32)) bus2 ();
  mem_wait_responder_if #(.ADDR_W(7), .DATA_W(32)) bus0 ();

  assign bus2.req = req;  assign bus2.we = we;  assign bus2.irwrite = irwrite;
  assign bus2.addr = addr;  assign bus2.wdata = wdata;
  assign bus0.req = req;  assign bus0.we = we;  assign bus0.irwrite = irwrite;
  assign bus0.addr = addr;  assign bus0.wdata = wdata;

  mem_wait_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2.slave)
  );
  mem_wait_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0.slave)
  );

  logic        m_ack, m_busy, m_overrun;
  logic [31:0] m_rdata, m_instr;
  assign m_ack     = sel ? bus2.ack     : bus0.ack;
  assign m_busy    = sel ? bus2.busy    : bus0.busy;
  assign m_overrun = sel ? bus2.overrun : bus0.overrun;
  assign m_rdata   = sel ? bus2.rdata   : bus0.rdata;
  assign m_instr   = sel ? bus2.instr   : bus0.instr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge: request in the current cycle, then scramble the
  // inputs so a late sample of them would be noticed.
  task automatic start(input logic w, input logic irw, input logic [6:0] a, input logic [31:0] d);
    req = 1'b1; we = w; irwrite = irw; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = ~w; irwrite = ~irw; addr = ~a; wdata = ~d;
  endtask

  task automatic wait_ack(input int cyc0, input int lat_exp);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (m_ack) begin
        seen = 1'b1;
      end else begin
        if (cyc < lat_exp) check_eq("busy_in_flight", 32'(m_busy), 32'd1);
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
    check_eq("ack_latency", cyc, lat_exp);
    check_eq("busy_at_ack", 32'(m_busy), 32'd0);
  endtask

  task automatic access(input logic w, input logic irw, input logic [6:0] a, input logic [31:0] d,
                        input int lat_exp);
    start(w, irw, a, d);
    wait_ack(1, lat_exp);
    $display("txn dut=W%0d %s addr=%0d irw=%0b wdata=0x%08h rdata=0x%08h instr=0x%08h",
             sel ? 2 : 0, w ? "WR" : "RD", a, irw, d, m_rdata, m_instr);
  endtask

  task automatic next_cycle_no_ack();
    @(negedge clk);
    check_eq("ack_one_cycle", 32'(m_ack), 32'd0);
  endtask

  task automatic count_idle_acks(input int n, input string tag);
    int acks;
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    check_eq(tag, acks, 0);
  endtask

  initial begin
    sel = 1'b1;
    rst2 = 1'b1; rst0 = 1'b1;
    req = 1'b0; we = 1'b0; irwrite = 1'b0; addr = '0; wdata = '0;

    // Reset and idle, WAIT_CYCLES=2
    @(negedge clk); @(negedge clk);
    check_eq("rst_ack", 32'(m_ack), 32'd0);
    check_eq("rst_busy", 32'(m_busy), 32'd0);
    check_eq("rst_rdata", m_rdata, 32'd0);
    check_eq("rst_instr", m_instr, 32'd0);
    check_eq("rst_overrun", 32'(m_overrun), 32'd0);
    rst2 = 1'b0; rst0 = 1'b0;
    count_idle_acks(10, "idle_no_ack");

    // Write then read back
    access(1'b1, 1'b0, 7'd5, 32'hDEADBEEF, 4);
    check_eq("wr_rdata_hold", m_rdata, 32'd0);
    next_cycle_no_ack();
    access(1'b0, 1'b0, 7'd5, 32'h0, 4);
    check_eq("rd5_rdata", m_rdata, 32'hDEADBEEF);
    check_eq("rd5_instr", m_instr, 32'd0);
    next_cycle_no_ack();

    // Instruction fetch, then data read leaves instr alone
    access(1'b1, 1'b0, 7'd0, 32'h20020005, 4);
    next_cycle_no_ack();
    access(1'b0, 1'b1, 7'd0, 32'h0, 4);
    check_eq("fetch_rdata", m_rdata, 32'h20020005);
    check_eq("fetch_instr", m_instr, 32'h20020005);
    next_cycle_no_ack();
    access(1'b0, 1'b0, 7'd5, 32'h0, 4);
    check_eq("data_rdata", m_rdata, 32'hDEADBEEF);
    check_eq("data_instr", m_instr, 32'h20020005);
    next_cycle_no_ack();

    // Overrun: a write pulse to addr 0 in T+2 must be dropped
    check_eq("overrun_clear", 32'(m_overrun), 32'd0);
    start(1'b0, 1'b0, 7'd5, 32'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; irwrite = 1'b0; addr = 7'd0; wdata = 32'hBAD0BAD0;
    @(negedge clk);
    req = 1'b0;
    wait_ack(3, 4);
    check_eq("ovr_rdata", m_rdata, 32'hDEADBEEF);
    check_eq("ovr_flag", 32'(m_overrun), 32'd1);
    $display("txn dut=W2 RD addr=5 with overrun pulse rdata=0x%08h overrun=%0b", m_rdata, m_overrun);
    // Back-to-back: request in the ack cycle
    access(1'b0, 1'b0, 7'd0, 32'h0, 4);
    check_eq("b2b_rdata", m_rdata, 32'h20020005);
    check_eq("ovr_sticky", 32'(m_overrun), 32'd1);
    next_cycle_no_ack();

    // Writes leave rdata/instr unchanged
    access(1'b1, 1'b0, 7'd9, 32'h11111111, 4);
    check_eq("wr_hold_rdata", m_rdata, 32'h20020005);
    check_eq("wr_hold_instr", m_instr, 32'h20020005);
    next_cycle_no_ack();

    // Mid-access reset aborts the write
    start(1'b1, 1'b0, 7'd9, 32'h12345678);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    check_eq("mid_rst_ack", 32'(m_ack), 32'd0);
    check_eq("mid_rst_busy", 32'(m_busy), 32'd0);
    check_eq("mid_rst_rdata", m_rdata, 32'd0);
    check_eq("mid_rst_instr", m_instr, 32'd0);
    check_eq("mid_rst_overrun", 32'(m_overrun), 32'd0);
    $display("txn dut=W2 WR addr=9 aborted by reset");
    count_idle_acks(6, "mid_rst_no_ack");
    access(1'b0, 1'b0, 7'd9, 32'h0, 4);
    check_eq("rd9_prior", m_rdata, 32'h11111111);
    next_cycle_no_ack();

    // WAIT_CYCLES=0 instance
    sel = 1'b0;
    rst0 = 1'b1;
    @(negedge clk); @(negedge clk);
    rst0 = 1'b0;
    check_eq("w0_rst_instr", m_instr, 32'd0);
    access(1'b1, 1'b0, 7'd3, 32'h55AA55AA, 2);
    next_cycle_no_ack();
    access(1'b0, 1'b1, 7'd3, 32'h0, 2);
    check_eq("w0_fetch_instr", m_instr, 32'h55AA55AA);
    next_cycle_no_ack();
    access(1'b1, 1'b1, 7'd3, 32'h77777777, 2);
    check_eq("w0_we_irw_instr", m_instr, 32'h55AA55AA);
    next_cycle_no_ack();
    access(1'b0, 1'b0, 7'd3, 32'h0, 2);
    check_eq("w0_rd3_rdata", m_rdata, 32'h77777777);
    check_eq("w0_rd3_instr", m_instr, 32'h55AA55AA);
    next_cycle_no_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Memory-side responder for the processor's unified instruction/data memory port, with a req/ack handshake and configurable wait states.
- Lets the multicycle processor run against slower memory.
- Holds the word array and the read-data register.
- Holds the instruction register, loaded on instruction-fetch reads.
- Sits between the processor's address mux (PC or ALU result) and storage, replacing the zero-latency memory.

Parameters:
- ADDR_W, 7, word-address width (memory depth = 2^ADDR_W words).
- DATA_W, 32, data word width.
- WAIT_CYCLES, 2, wait states inserted before ack; legal range 0..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled only when busy=0.
- we  input  1  1 = write access, 0 = read access.
- irwrite  input  1  on a read, also load instr with the read word.
- addr  input  ADDR_W  word address (byte address bits [ADDR_W+1:2] from the initiator).
- wdata  input  DATA_W  write data.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  access in flight; req is ignored while busy is high.
- rdata  output  DATA_W  registered read data.
- instr  output  DATA_W  instruction register.
- overrun  output  1  sticky flag: req was asserted while busy.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - ack=0, busy=0, rdata=0, instr=0, overrun=0.
  - Wait counter=0.
  - Memory array is not cleared.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - If req=1 at a rising edge, capture we, irwrite, addr and wdata into request registers.
  - Load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
  - If req=0, stay in IDLE.
- WAIT: decrement the counter each edge; when it reaches 1, next state is ACCESS.
- ACCESS (one cycle), on exit edge:
  - Write: mem[addr_q] <= wdata_q.
  - Read: rdata <= mem[addr_q]; if irwrite_q, also instr <= mem[addr_q].
  - ack goes to 1 for the following cycle; next state is IDLE.
- Latency:
  - req high in cycle T (busy=0) -> ack high in cycle T+2+WAIT_CYCLES, for exactly one cycle.
  - busy=1 during cycles T+1 .. T+1+WAIT_CYCLES; busy=0 during the ack cycle.
- Back-to-back:
  - A req in the ack cycle is accepted.
  - Sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Data hold:
  - rdata holds until the next completed read; writes leave rdata unchanged.
  - instr changes only on a read with irwrite_q=1.
- we=1 and irwrite=1 together: the write is performed, instr is unchanged, and no error is raised.
- Read-after-write to the same address in the next access returns the new data.
- req while busy=1: the request is ignored, the in-flight access is unaffected, and overrun <= 1 (cleared only by reset).
- Input changes after acceptance (addr, wdata, we) have no effect on the in-flight access.
- Reset mid-access: the access is aborted, no write is committed, no ack is issued, and rdata/instr are cleared to 0.
- Address: full ADDR_W range is valid and there is no wrap logic; an out-of-range address is impossible by width.

Test Plan:
- Reset then idle, WAIT_CYCLES=2: assert reset 2 cycles -> ack=0, busy=0, rdata=0, instr=0, overrun=0; no ack for 10 idle cycles.
- Write then read: write 0xDEADBEEF to addr 5 (req in cycle T) -> ack in cycle T+4 only, busy high T+1..T+3. Then read addr 5 with irwrite=0 -> rdata=0xDEADBEEF at ack, instr still 0.
- Instruction fetch: preload addr 0 = 0x20020005, read with irwrite=1 -> rdata=instr=0x20020005. Then data read of addr 5 -> rdata=0xDEADBEEF, instr stays 0x20020005.
- Overrun and back-to-back:
  - Pulse req in cycle T+2 of an in-flight read -> ignored, overrun=1, exactly one ack.
  - A new req in the ack cycle -> accepted, next ack 4 cycles later.
- Mid-access reset: start a write of 0x12345678 to addr 9, assert reset in cycle T+2 -> no ack, all outputs 0. Subsequent read of addr 9 returns its prior value, not 0x12345678.
- WAIT_CYCLES=0 build: req in cycle T -> ack in cycle T+2, busy high only in T+1; simultaneous we=1/irwrite=1 to addr 3 -> mem[3] written, instr unchanged.
